// File: rtl/alu_md_control.sv
// alu_md_control: EX-stage ALU function decode plus 32-cycle MUL/DIV with HI/LO.
// Define MDU_SIGNED_EN to add signed MULT (18) / DIV (1A).
module alu_md_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [3:0]  ALUop,
  input  logic        rtype,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] md_rdata,
  output logic        md_rsel,
  output logic        busy,
  output logic        stall
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state, state_nx;

  logic [31:0] hi, lo;
  logic [63:0] acc;
  logic [31:0] opd;
  logic [4:0]  cnt;
  logic [31:0] ma, mb;

  logic is_mul, is_div, is_mf, is_mt;
  logic md_op, issue, done;

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] dsub;
  logic [63:0] step, res;

  always_comb begin
    alu_ctrl = ALU_ADD;
    if (!rtype) begin
      unique case (ALUop)
        4'b1111: alu_ctrl = ALU_AND;
        4'b1101: alu_ctrl = ALU_SLT;
        4'b0000: alu_ctrl = ALU_OR;
        default: alu_ctrl = ALU_ADD;
      endcase
    end else begin
      unique case (funct)
        6'h20, 6'h21: alu_ctrl = ALU_ADD;
        6'h22, 6'h23: alu_ctrl = ALU_SUB;
        6'h24:        alu_ctrl = ALU_AND;
        6'h25:        alu_ctrl = ALU_OR;
        6'h26:        alu_ctrl = ALU_XOR;
        6'h27:        alu_ctrl = ALU_NOR;
        6'h2A:        alu_ctrl = ALU_SLT;
        6'h2B:        alu_ctrl = ALU_SLTU;
        6'h00:        alu_ctrl = ALU_SLL;
        6'h02:        alu_ctrl = ALU_SRL;
        6'h03:        alu_ctrl = ALU_SRA;
        default:      alu_ctrl = ALU_ADD;
      endcase
    end
  end

  assign is_mf = rtype & (funct == 6'h10 | funct == 6'h12);
  assign is_mt = rtype & (funct == 6'h11 | funct == 6'h13);

`ifdef MDU_SIGNED_EN
  logic sgn, neg_q, neg_r;
  assign is_mul = rtype & (funct == 6'h19 | funct == 6'h18);
  assign is_div = rtype & (funct == 6'h1B | funct == 6'h1A);
  // signed variants are the even funct codes
  assign sgn = ~funct[0];
  assign ma  = (sgn & a[31]) ? -a : a;
  assign mb  = (sgn & b[31]) ? -b : b;
`else
  assign is_mul = rtype & (funct == 6'h19);
  assign is_div = rtype & (funct == 6'h1B);
  assign ma = a;
  assign mb = b;
`endif

  assign md_op    = is_mul | is_div | is_mf | is_mt;
  assign busy     = (state != S_IDLE);
  assign issue    = valid & md_op & ~busy;
  assign stall    = valid & md_op & busy;
  assign done     = busy & (cnt == 5'd31);
  assign md_rsel  = valid & is_mf;
  assign md_rdata = (funct == 6'h10) ? hi : lo;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    rem_sh = acc[63:31];
    ge     = (rem_sh >= {1'b0, opd});
    dsub   = rem_sh[31:0] - opd;
    if (state == S_MUL)
      step = {sum, acc[31:1]};
    else
      step = {(ge ? dsub : rem_sh[31:0]), acc[30:0], ge};
    res = step;
`ifdef MDU_SIGNED_EN
    if (state == S_MUL) begin
      if (neg_q) res = -step;
    end else begin
      if (neg_r) res[63:32] = -step[63:32];
      if (neg_q) res[31:0]  = -step[31:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (issue & is_mul)      state_nx = S_MUL;
        else if (issue & is_div) state_nx = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cnt == 5'd31) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi  <= 32'd0;
      lo  <= 32'd0;
      acc <= 64'd0;
      opd <= 32'd0;
      cnt <= 5'd0;
`ifdef MDU_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      if (issue & (is_mul | is_div)) begin
        acc <= is_mul ? {32'd0, mb} : {32'd0, ma};
        opd <= is_mul ? ma : mb;
        cnt <= 5'd0;
`ifdef MDU_SIGNED_EN
        neg_q <= sgn & (a[31] ^ b[31]);
        neg_r <= sgn & a[31];
`endif
      end else if (busy) begin
        acc <= step;
        cnt <= cnt + 5'd1;
        if (done) begin
          hi <= res[63:32];
          lo <= res[31:0];
        end
      end
      if (issue & rtype & (funct == 6'h11)) hi <= a;
      if (issue & rtype & (funct == 6'h13)) lo <= a;
    end
  end

endmodule

// File: tb/tb_alu_md_control.sv
// tb_alu_md_control: randomized self-checking bench for alu_md_control.
// Reference model uses plain 64-bit arithmetic and a decode table.
module tb_alu_md_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  ALUop;
  logic        rtype;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] md_rdata;
  logic        md_rsel;
  logic        busy;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  alu_md_control dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .ALUop    (ALUop),
    .rtype    (rtype),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .md_rdata (md_rdata),
    .md_rsel  (md_rsel),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_ctrl(input logic rt, input logic [3:0] op,
                                          input logic [5:0] f);
    logic [3:0] ftab [64];
    foreach (ftab[i]) ftab[i] = 4'd0;
    ftab[6'h22] = 4'd1;  ftab[6'h23] = 4'd1;
    ftab[6'h24] = 4'd2;  ftab[6'h25] = 4'd3;
    ftab[6'h26] = 4'd4;  ftab[6'h27] = 4'd5;
    ftab[6'h2A] = 4'd6;  ftab[6'h2B] = 4'd7;
    ftab[6'h00] = 4'd8;  ftab[6'h02] = 4'd9;
    ftab[6'h03] = 4'd10;
    if (rt) return ftab[f];
    if (op == 4'b1111) return 4'd2;
    if (op == 4'b1101) return 4'd6;
    if (op == 4'b0000) return 4'd3;
    return 4'd0;
  endfunction

  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] x,
                                           input logic [31:0] y);
    int sx, sy, q, r;
    longint p;
    sx = int'(x);
    sy = int'(y);
    case (f)
      6'h19: return {32'd0, x} * {32'd0, y};
      6'h1B: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      6'h18: begin
        p = longint'(sx) * longint'(sy);
        return 64'(p);
      end
      6'h1A: begin
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    valid = 1'b0;
    rtype = 1'b0;
    funct = 6'h20;
    ALUop = 4'b1010;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    valid = 1'b0;
    rtype = 1'b1;
    funct = 6'h10;
    #1 h = md_rdata;
    funct = 6'h12;
    #1 l = md_rdata;
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output int cyc);
    valid = 1'b1;
    rtype = 1'b1;
    funct = f;
    a = x;
    b = y;
    tick();
    valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    valid = 1'b1;
    rtype = 1'b1;
    funct = 6'h11;
    a = h;
    tick();
    funct = 6'h13;
    a = l;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    idle();
    rst = 1'b1;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy got %0b want 0", busy);
    end
    valid = 1'b1;
    rtype = 1'b1;
    funct = 6'h12;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_stall got %0b want 0", stall);
    end
    read_hilo(h, l);
    n_cmp++;
    if (h !== 32'd0 || l !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_hilo got %h_%h want 0_0", h, l);
    end
    idle();
  endtask

  task automatic test_alu_ctrl;
    logic [3:0] ops [4] = '{4'b1010, 4'b1111, 4'b1101, 4'b0000};
    logic [3:0] exp;
    rtype = 1'b0; ALUop = 4'b1111; #1;
    n_cmp++;
    if (alu_ctrl !== 4'd2) begin n_bad++; $display("FAIL alu_and got %0d want 2", alu_ctrl); end
    ALUop = 4'b1101; #1;
    n_cmp++;
    if (alu_ctrl !== 4'd6) begin n_bad++; $display("FAIL alu_slt got %0d want 6", alu_ctrl); end
    rtype = 1'b1; funct = 6'h2B; #1;
    n_cmp++;
    if (alu_ctrl !== 4'd7) begin n_bad++; $display("FAIL alu_sltu got %0d want 7", alu_ctrl); end
    funct = 6'h03; #1;
    n_cmp++;
    if (alu_ctrl !== 4'd10) begin n_bad++; $display("FAIL alu_sra got %0d want 10", alu_ctrl); end
    for (int i = 0; i < 60; i++) begin
      rtype = 1'($urandom);
      ALUop = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 3)] : 4'($urandom);
      funct = ($urandom_range(0, 1) == 0) ? (6'h20 + 6'($urandom_range(0, 11))) : 6'($urandom);
      #1;
      exp = ref_ctrl(rtype, ALUop, funct);
      n_cmp++;
      if (alu_ctrl !== exp) begin
        n_bad++;
        $display("FAIL alu_rand rt=%0b op=%b f=%h got %0d want %0d",
                 rtype, ALUop, funct, alu_ctrl, exp);
      end
    end
    idle();
  endtask

  task automatic test_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] h, l;
    logic [63:0] exp;
    int cyc;
    exp = md_model(f, x, y);
    run_md(f, x, y, cyc);
    n_cmp++;
    if (cyc != 32) begin
      n_bad++;
      $display("FAIL md_latency f=%h got %0d want 32", f, cyc);
    end
    read_hilo(h, l);
    n_cmp++;
    if ({h, l} !== exp) begin
      n_bad++;
      $display("FAIL md_result f=%h a=%h b=%h got %h_%h want %h", f, x, y, h, l, exp);
    end
    idle();
  endtask

  task automatic test_multu;
    test_md(6'h19, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 5; i++) test_md(6'h19, $urandom, $urandom);
  endtask

  task automatic test_divu;
    test_md(6'h1B, 32'd100, 32'd7);
    test_md(6'h1B, 32'd5, 32'd0);
    for (int i = 0; i < 5; i++)
      test_md(6'h1B, $urandom, (i == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 28)));
  endtask

  task automatic test_mt_mf;
    valid = 1'b1; rtype = 1'b1; funct = 6'h11; a = 32'h1234;
    tick();
    funct = 6'h10;
    #1;
    n_cmp++;
    if (md_rdata !== 32'h1234 || md_rsel !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mthi_mfhi got %h rsel=%0b stall=%0b busy=%0b want 1234 1 0 0",
               md_rdata, md_rsel, stall, busy);
    end
    funct = 6'h13; a = $urandom;
    tick();
    funct = 6'h12;
    #1;
    n_cmp++;
    if (md_rdata !== a || md_rsel !== 1'b1) begin
      n_bad++;
      $display("FAIL mtlo_mflo got %h rsel=%0b want %h 1", md_rdata, md_rsel, a);
    end
    valid = 1'b0;
    #1;
    n_cmp++;
    if (md_rsel !== 1'b0) begin
      n_bad++;
      $display("FAIL rsel_novalid got %0b want 0", md_rsel);
    end
    idle();
  endtask

  task automatic test_stall_mflo;
    int n = 0;
    int bad = 0;
    valid = 1'b1; rtype = 1'b1; funct = 6'h19; a = 32'hFFFFFFFF; b = 32'd2;
    tick();
    funct = 6'h12;
    while (busy && n < 40) begin
      #1;
      if (!stall || !md_rsel) bad++;
      tick();
      n++;
    end
    n_cmp++;
    if (n != 32 || bad != 0) begin
      n_bad++;
      $display("FAIL mflo_stall got cycles=%0d nostall=%0d want 32 0", n, bad);
    end
    n_cmp++;
    if (stall !== 1'b0 || md_rdata !== 32'hFFFFFFFE) begin
      n_bad++;
      $display("FAIL mflo_after got stall=%0b %h want 0 fffffffe", stall, md_rdata);
    end
    funct = 6'h10;
    #1;
    n_cmp++;
    if (md_rdata !== 32'd1) begin
      n_bad++;
      $display("FAIL mfhi_after got %h want 1", md_rdata);
    end
    idle();
  endtask

  task automatic test_reset_abort;
    logic [31:0] h, l;
    int bad = 0;
    write_hilo(32'hABCD, 32'h5555);
    valid = 1'b1; rtype = 1'b1; funct = 6'h19; a = 32'd3; b = 32'd4;
    tick();
    funct = 6'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (stall !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL nonmd_stall got bad=%0d want 0", bad);
    end
    valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy got %0b want 0", busy);
    end
    read_hilo(h, l);
    n_cmp++;
    if (h !== 32'd0 || l !== 32'd0) begin
      n_bad++;
      $display("FAIL abort_hilo got %h_%h want 0_0", h, l);
    end
    repeat (40) tick();
    read_hilo(h, l);
    n_cmp++;
    if (h !== 32'd0 || l !== 32'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_late got %h_%h busy=%0b want 0_0 0", h, l, busy);
    end
    idle();
  endtask

  task automatic test_back_to_back;
    logic [31:0] x1, y1, x2, y2, h, l;
    logic [63:0] e1, e2;
    int n = 0;
    int m = 0;
    int bad = 0;
    x1 = $urandom; y1 = $urandom;
    x2 = $urandom; y2 = 32'($urandom_range(1, 65535));
    e1 = md_model(6'h19, x1, y1);
    e2 = md_model(6'h1B, x2, y2);
    valid = 1'b1; rtype = 1'b1; funct = 6'h19; a = x1; b = y1;
    tick();
    funct = 6'h1B; a = x2; b = y2;
    while (busy && n < 40) begin
      #1;
      if (!stall) bad++;
      tick();
      n++;
    end
    n_cmp++;
    if (n != 32 || bad != 0 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first got cycles=%0d nostall=%0d stall=%0b want 32 0 0", n, bad, stall);
    end
    n_cmp++;
    if (md_rdata !== e1[31:0]) begin
      n_bad++;
      $display("FAIL b2b_lo1 got %h want %h", md_rdata, e1[31:0]);
    end
    tick();
    valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_reissue got busy=%0b want 1", busy);
    end
    while (busy && m < 40) begin
      tick();
      m++;
    end
    read_hilo(h, l);
    n_cmp++;
    if (m != 32 || {h, l} !== e2) begin
      n_bad++;
      $display("FAIL b2b_second got cycles=%0d %h_%h want 32 %h", m, h, l, e2);
    end
    idle();
  endtask

`ifdef MDU_SIGNED_EN
  task automatic test_signed;
    test_md(6'h18, -32'sd3, 32'd5);
    test_md(6'h1A, -32'sd7, 32'd2);
    test_md(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      test_md(6'h18, $urandom, $urandom);
      test_md(6'h1A, $urandom, 32'($urandom_range(1, 1000)) * (i[0] ? 32'hFFFFFFFF : 32'd1));
    end
  endtask
`else
  task automatic test_unsigned_only;
    logic [31:0] h, l;
    write_hilo(32'h600D, 32'hF00D);
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; rtype = 1'b1; funct = i[0] ? 6'h1A : 6'h18;
      a = $urandom; b = $urandom;
      #1;
      n_cmp++;
      if (stall !== 1'b0 || alu_ctrl !== 4'd0) begin
        n_bad++;
        $display("FAIL nosigned_dec f=%h got stall=%0b ctrl=%0d want 0 0", funct, stall, alu_ctrl);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL nosigned_busy f=%h got %0b want 0", funct, busy);
      end
    end
    read_hilo(h, l);
    n_cmp++;
    if (h !== 32'h600D || l !== 32'hF00D) begin
      n_bad++;
      $display("FAIL nosigned_hilo got %h_%h want 600d_f00d", h, l);
    end
    idle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    a = 32'd0;
    b = 32'd0;
    idle();
    test_reset();
    test_alu_ctrl();
    test_multu();
    test_divu();
    test_mt_mf();
    test_stall_mflo();
    test_reset_abort();
    test_back_to_back();
`ifdef MDU_SIGNED_EN
    test_signed();
`else
    test_unsigned_only();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_md_control.md
# alu_md_control

Second-level ALU control for the MIPS core. Consumes the 4-bit ALUop produced by the opcode-level ALU decoder plus the R-type funct field, and drives the function select of the single-cycle ALU. Also owns an iterative 32-cycle multiply/divide unit with HI/LO registers and a stall output for the pipeline. Sits in EX, between the decode-stage control outputs and the ALU / writeback mux.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  EX-stage instruction present this cycle
- ALUop  in  4  from opcode decoder: 4'b1010 add/R-type, 4'b1111 and, 4'b1101 slt, 4'b0000 or
- rtype  in  1  instruction is R-type (op == 0); only then is funct consulted
- funct  in  6  instruction[5:0]
- a  in  32  rs operand
- b  in  32  rt operand
- alu_ctrl  out  4  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA
- md_rdata  out  32  HI (MFHI) or LO (MFLO) value, combinational
- md_rsel  out  1  writeback selects md_rdata instead of ALU result
- busy  out  1  multiply/divide iteration in progress (registered)
- stall  out  1  hold pipeline this cycle (combinational)

## Operation
- alu_ctrl (combinational): rtype=0 → map ALUop (1010→ADD, 1111→AND, 1101→SLT, 0000→OR, other→ADD). rtype=1 → funct: 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA, other ADD.
- MD ops (rtype=1): 19 MULTU, 1B DIVU, 10 MFHI, 12 MFLO, 11 MTHI (HI←a), 13 MTLO (LO←a). 18 MULT / 1A DIV only with macro (see Configuration); without it they decode as ADD, no MD action.
- md_rsel = valid & rtype & funct∈{10,12}; md_rdata = HI if funct==10 else LO.
- Issue: valid & rtype & MD op & !busy. Mult/div issue latches operands, clears 5-bit counter, sets busy.
- Multiply: shift-add, one partial product per cycle, 64-bit result {HI,LO}.
- Divide: restoring, one quotient bit per cycle; LO←quotient, HI←remainder.
- Divide by zero: runs full 32 cycles; LO←32'hFFFFFFFF, HI←dividend. No exception.
- MTHI/MTLO write in the issue cycle (one edge), no busy.
- stall = busy & valid & rtype & MD op (any of MULT(U)/DIV(U)/MFHI/MFLO/MTHI/MTLO). Non-MD instructions never stall.
- Reset: HI=0, LO=0, busy=0, counter=0; aborts any in-flight operation, no HI/LO update.

## Timing
- Issue at edge E0; busy=1 from E0 through E32; at E32 HI/LO written and busy←0 on the same edge.
- MFHI/MFLO in the cycle after E32 returns the new result; during busy it is stalled.
- alu_ctrl, md_rdata, md_rsel, stall: zero-latency combinational.
- Issue while busy impossible: stall holds it; it issues the cycle after busy falls.
- Back-to-back MD ops: second issues at E32, busy never drops for a visible cycle? No — busy falls at E32, second issues at E33 edge (one idle cycle).
- Reset outputs: busy=0, stall=0, md_rdata=0 (HI=LO=0); alu_ctrl per inputs.

## Configuration
- MDU_SIGNED_EN defined: MULT (18) and DIV (1A) supported; operands converted to magnitude at issue, results negated at completion: product/quotient sign = a[31]^b[31], remainder takes sign of dividend; 32'h80000000 / -1 gives LO=32'h80000000, HI=0. Same 32-cycle latency.
- Not defined: unsigned MULTU/DIVU only; funct 18/1A behave as ADD, no stall, no HI/LO change.

## Test plan
- rtype=0, ALUop 1111 → alu_ctrl=2; ALUop 1101 → 6; rtype=1 funct 2B → 7, funct 03 → 10.
- MULTU a=32'hFFFFFFFF b=2 → busy 32 cycles, then HI=1, LO=32'hFFFFFFFE; MFLO issued at E1 stalls until busy=0 then reads 32'hFFFFFFFE.
- DIVU a=100 b=7 → LO=14, HI=2 after 32 cycles; DIVU a=5 b=0 → LO=32'hFFFFFFFF, HI=5.
- MTHI a=32'h1234 then MFHI next cycle → md_rdata=32'h1234, md_rsel=1, stall=0.
- rst asserted at cycle 10 of MULTU 3×4 → busy=0, HI=LO=0 next cycle, no later writeback.
- With MDU_SIGNED_EN: MULT -3×5 → {HI,LO}=64'hFFFFFFFF_FFFFFFF1; DIV -7/2 → LO=-3, HI=-1.
